serial_word_receiver: RTL and testbench



---
 rtl/serial_word_receiver_if.sv | 34 +++
 rtl/serial_word_receiver.sv | 112 +++++++++++
 tb/tb_serial_word_receiver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_word_receiver_if.sv
// Bus between a bit-serial producer (master) and serial_word_receiver (slave).
// The parity signal exists only when SERIAL_RX_PARITY_EN is defined.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic             sin;
    logic             sin_cout;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             cout_out;
    logic             done;
    logic             busy;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity;
`endif

    modport master (
        output start, abort, sin, sin_cout, sin_valid,
        input  dout, cout_out, done, busy
`ifdef SERIAL_RX_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  start, abort, sin, sin_cout, sin_valid,
        output dout, cout_out, done, busy
`ifdef SERIAL_RX_PARITY_EN
        , output parity
`endif
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Deserializes an LSB-first bit stream (plus carry) into a WIDTH-bit word; optional parity via SERIAL_RX_PARITY_EN.
// Latency: done/dout valid the cycle after the edge accepting the WIDTH-th bit.
// Backpressure: none upstream; sin_valid=0 stalls the shift indefinitely, abort drops the frame.
module serial_word_receiver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_word_receiver_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    // Only WIDTH-1 bits need storing: the final bit goes straight from sin into dout.
    logic [WIDTH-2:0] shreg;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dout_q;
    logic             cout_q;
    logic             done_q;
    logic             busy_q;
    logic [WIDTH-1:0] word_next;
    logic             last_bit;

    assign word_next = {bus.sin, shreg};
    assign last_bit  = (count == CNT_W'(WIDTH - 1));

    assign bus.dout     = dout_q;
    assign bus.cout_out = cout_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

`ifdef SERIAL_RX_PARITY_EN
    logic parity_q;
    assign bus.parity = parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (!bus.abort && state == SHIFT && bus.sin_valid && last_bit) begin
            parity_q <= ^{word_next, bus.sin_cout};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            dout_q <= '0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else if (bus.abort) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shreg  <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.sin_valid) begin
                        shreg <= word_next[WIDTH-1:1];
                        if (last_bit) begin
                            count  <= '0;
                            dout_q <= word_next;
                            cout_q <= bus.sin_cout;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shreg  <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: expected words queued at the last bit, checked on done.
module tb_serial_word_receiver;
    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_word_receiver_if #(.WIDTH(WIDTH)) rx_if ();

    serial_word_receiver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rx_if.slave)
    );

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             cout;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // done is a one-cycle pulse; every observed pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rx_if.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(rx_if.done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("dout", 32'(rx_if.dout), 32'(e.word));
                check("cout_out", 32'(rx_if.cout_out), 32'(e.cout));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_RX_PARITY_EN
                check("parity", 32'(rx_if.parity), 32'(^{e.word, e.cout}));
`endif
            end
        end
    end

    // Sends one frame (bit i of w goes out i-th); stalls stall_len cycles after bit stall_at.
    task automatic frame(input logic [WIDTH-1:0] w, input logic c, input int stall_at, input int stall_len);
        rx_if.start = 1'b1;
        tick();
        rx_if.start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_in_frame", 32'(rx_if.busy), 32'd1);
            rx_if.sin       = w[i];
            rx_if.sin_cout  = (i == WIDTH - 1) ? c : ~c;
            rx_if.sin_valid = 1'b1;
            if (i == WIDTH - 1) sb.push_back('{w, c, cyc + 1});
            tick();
            rx_if.sin_valid = 1'b0;
            rx_if.sin       = 1'($urandom);
            rx_if.sin_cout  = 1'($urandom);
            if (i == stall_at && i != WIDTH - 1) begin
                for (int s = 0; s < stall_len; s++) begin
                    check("busy_stall", 32'(rx_if.busy), 32'd1);
                    tick();
                end
            end
        end
        check("busy_after", 32'(rx_if.busy), 32'd0);
    endtask

    task automatic partial(input int nbits);
        rx_if.start = 1'b1;
        tick();
        rx_if.start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            rx_if.sin       = 1'b1;
            rx_if.sin_cout  = 1'b1;
            rx_if.sin_valid = 1'b1;
            tick();
        end
        rx_if.sin_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        rx_if.start     = 1'b0;
        rx_if.abort     = 1'b0;
        rx_if.sin       = 1'b0;
        rx_if.sin_cout  = 1'b0;
        rx_if.sin_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_dout", 32'(rx_if.dout), 32'd0);
        check("rst_cout", 32'(rx_if.cout_out), 32'd0);
        check("rst_done", 32'(rx_if.done), 32'd0);
        check("rst_busy", 32'(rx_if.busy), 32'd0);
`ifdef SERIAL_RX_PARITY_EN
        check("rst_parity", 32'(rx_if.parity), 32'd0);
`endif

        // sin_valid alone in IDLE must not start collecting
        rx_if.sin_valid = 1'b1;
        rx_if.sin       = 1'b1;
        tick();
        tick();
        rx_if.sin_valid = 1'b0;
        check("idle_ignores_valid", 32'(rx_if.busy), 32'd0);

        frame(4'b1101, 1'b1, WIDTH, 0);
        tick();
        frame(4'b1101, 1'b1, 1, 3);
        // back-to-back: second start lands in the DONE cycle
        frame(4'b0110, 1'b0, WIDTH, 0);
        tick();

        partial(2);
        rx_if.abort     = 1'b1;
        rx_if.sin_valid = 1'b1;
        rx_if.start     = 1'b1;
        tick();
        rx_if.abort     = 1'b0;
        rx_if.sin_valid = 1'b0;
        rx_if.start     = 1'b0;
        check("abort_busy", 32'(rx_if.busy), 32'd0);
        check("abort_dout_hold", 32'(rx_if.dout), 32'b0110);
        check("abort_cout_hold", 32'(rx_if.cout_out), 32'd0);
        tick();
        frame(4'b1000, 1'b0, WIDTH, 0);
        tick();

        partial(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_dout", 32'(rx_if.dout), 32'd0);
        check("midrst_cout", 32'(rx_if.cout_out), 32'd0);
        check("midrst_busy", 32'(rx_if.busy), 32'd0);
        check("midrst_done", 32'(rx_if.done), 32'd0);
`ifdef SERIAL_RX_PARITY_EN
        check("midrst_parity", 32'(rx_if.parity), 32'd0);
`endif
        frame(4'b1111, 1'b1, WIDTH, 0);
        frame(4'b0001, 1'b0, WIDTH, 0);
        tick();

        for (int k = 0; k < 8; k++) begin
            frame(4'($urandom), 1'($urandom), int'($urandom_range(0, WIDTH - 1)),
                  int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
